uart_game_decoder: RTL and testbench

//  Receive-side counterpart of the game-state UART link: pops bytes from the UART RX FIFO and parses the

---
 rtl/uart_game_decoder.sv | 264 ++++++++++++++++++++++++++
 tb/tb_uart_game_decoder.sv | 517 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_game_decoder.sv
// uart_game_decoder
//   Receive side of the game-state UART link. Pops bytes from the RX FIFO and
//   parses the fixed 49-byte ASCII frame
//     "CX:ddd,Y:ddd|H:d|A:d|F:b|T:d|BX:ddd,Y:ddd|BH:dd\r\n"
//   Digit bytes are 0x30..0x3F, and each one carries a hex nibble, MSB first.
//   Parsed nibbles land in shadow registers. The shadow registers are copied to
//   the rem_* outputs in a single step, and only once the whole frame has
//   checked out. A partial or bad frame never disturbs the outputs.
//
// Optional build macro:
//   UART_DEC_TIMEOUT_EN - abandon a frame (frame_err, back to HUNT) after
//                         TIMEOUT_CYCLES idle clocks between bytes.
//
// Ports:
//   clk, rst        system clock, asynchronous active-high reset
//   rx_data         byte at RX FIFO head, valid while rx_empty = 0
//   rx_empty        RX FIFO empty flag
//   rx_rd           pop strobe; rx_data is consumed in the same cycle
//   rem_char_x/y    remote character position (12 bit)
//   rem_char_hp     remote character hp (4 bit)
//   rem_aggro       remote aggro (4 bit)
//   rem_flip_h      remote sprite flip
//   rem_class       remote character class (2 bit)
//   rem_boss_x/y    boss position (12 bit)
//   rem_boss_hp     boss hp (7 bit)
//   frame_ok        1-cycle pulse, rem_* outputs were just updated
//   frame_err       1-cycle pulse, partial frame discarded
//   frame_cnt       good-frame counter, wraps 255 -> 0
module uart_game_decoder #(
    parameter int unsigned DATA_WIDTH     = 8,
    parameter int unsigned TIMEOUT_CYCLES = 1_000_000
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [DATA_WIDTH-1:0] rx_data,
    input  logic                  rx_empty,
    output logic                  rx_rd,
    output logic [11:0]           rem_char_x,
    output logic [11:0]           rem_char_y,
    output logic [3:0]            rem_char_hp,
    output logic [3:0]            rem_aggro,
    output logic                  rem_flip_h,
    output logic [1:0]            rem_class,
    output logic [11:0]           rem_boss_x,
    output logic [11:0]           rem_boss_y,
    output logic [6:0]            rem_boss_hp,
    output logic                  frame_ok,
    output logic                  frame_err,
    output logic [7:0]            frame_cnt
);

    if (DATA_WIDTH != 8 || TIMEOUT_CYCLES < 1) begin : g_param_check
        $error("uart_game_decoder: DATA_WIDTH must be 8 and TIMEOUT_CYCLES >= 1");
    end

    typedef enum logic [1:0] {
        S_HUNT,
        S_RECV,
        S_COMMIT
    } state_t;

    localparam logic [7:0] CH_C  = 8'h43;
    localparam logic [5:0] IDX_LAST = 6'd48;

    state_t      r_state, w_next_state;
    logic [5:0]  r_idx, w_next_idx;
    logic        w_byte_ok;
    logic        w_err;
    logic        w_commit;
    logic        w_timeout;
    logic        w_sh_we;
    logic [3:0]  w_nib;

    logic [11:0] r_sh_x, r_sh_y, r_sh_bx, r_sh_by;
    logic [3:0]  r_sh_hp, r_sh_aggro;
    logic        r_sh_flip;
    logic [1:0]  r_sh_class;
    logic [6:0]  r_sh_bh;

    // Per-position byte check: template characters must match exactly,
    // digit positions accept 0x30..0x3F, with tighter ranges for F, T and BH-high.
    always_comb begin
        w_byte_ok = 1'b0;
        w_nib     = rx_data[3:0];
        case (r_idx)
            6'd1, 6'd30:                                   w_byte_ok = (rx_data == 8'h58); // 'X'
            6'd2, 6'd8, 6'd14, 6'd18, 6'd22, 6'd26,
            6'd31, 6'd37, 6'd44:                           w_byte_ok = (rx_data == 8'h3A); // ':'
            6'd6, 6'd35:                                   w_byte_ok = (rx_data == 8'h2C); // ','
            6'd7, 6'd36:                                   w_byte_ok = (rx_data == 8'h59); // 'Y'
            6'd12, 6'd16, 6'd20, 6'd24, 6'd28, 6'd41:      w_byte_ok = (rx_data == 8'h7C); // '|'
            6'd13, 6'd43:                                  w_byte_ok = (rx_data == 8'h48); // 'H'
            6'd17:                                         w_byte_ok = (rx_data == 8'h41); // 'A'
            6'd21:                                         w_byte_ok = (rx_data == 8'h46); // 'F'
            6'd25:                                         w_byte_ok = (rx_data == 8'h54); // 'T'
            6'd29, 6'd42:                                  w_byte_ok = (rx_data == 8'h42); // 'B'
            6'd47:                                         w_byte_ok = (rx_data == 8'h0D);
            6'd48:                                         w_byte_ok = (rx_data == 8'h0A);
            6'd3, 6'd4, 6'd5, 6'd9, 6'd10, 6'd11, 6'd15, 6'd19,
            6'd32, 6'd33, 6'd34, 6'd38, 6'd39, 6'd40, 6'd46:
                                                           w_byte_ok = (rx_data[7:4] == 4'h3);
            6'd23:                                         w_byte_ok = (rx_data[7:1] == 7'b0011_000);
            6'd27:                                         w_byte_ok = (rx_data[7:2] == 6'b0011_00);
            6'd45:                                         w_byte_ok = (rx_data[7:3] == 5'b0011_0);
            default:                                       w_byte_ok = 1'b0;
        endcase
    end

`ifdef UART_DEC_TIMEOUT_EN
    localparam int unsigned GAP_W = $clog2(TIMEOUT_CYCLES + 1);

    logic [GAP_W-1:0] r_gap;

    // Fires on the TIMEOUT_CYCLES-th consecutive idle cycle inside a frame.
    assign w_timeout = (r_state == S_RECV) && !rx_rd &&
                       (r_gap == GAP_W'(TIMEOUT_CYCLES - 1));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_gap <= '0;
        end else if (r_state != S_RECV || rx_rd || w_timeout) begin
            r_gap <= '0;
        end else begin
            r_gap <= r_gap + 1'b1;
        end
    end
`else
    assign w_timeout = 1'b0;
`endif

    // FIFO is never popped during the commit cycle.
    assign rx_rd = !rx_empty && (r_state != S_COMMIT);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= S_HUNT;
            r_idx   <= '0;
        end else begin
            r_state <= w_next_state;
            r_idx   <= w_next_idx;
        end
    end

    always_comb begin
        w_next_state = r_state;
        w_next_idx   = r_idx;
        w_err        = 1'b0;
        w_commit     = 1'b0;
        case (r_state)
            S_HUNT: begin
                w_next_idx = '0;
                if (rx_rd && rx_data == CH_C) begin
                    w_next_state = S_RECV;
                    w_next_idx   = 6'd1;
                end
            end
            S_RECV: begin
                if (w_timeout) begin
                    w_err        = 1'b1;
                    w_next_state = S_HUNT;
                    w_next_idx   = '0;
                end else if (rx_rd) begin
                    if (w_byte_ok) begin
                        if (r_idx == IDX_LAST) begin
                            w_next_state = S_COMMIT;
                            w_next_idx   = '0;
                        end else begin
                            w_next_idx = r_idx + 6'd1;
                        end
                    end else begin
                        w_err = 1'b1;
                        // A stray 'C' is treated as the start of a new frame.
                        if (rx_data == CH_C) begin
                            w_next_idx = 6'd1;
                        end else begin
                            w_next_state = S_HUNT;
                            w_next_idx   = '0;
                        end
                    end
                end
            end
            S_COMMIT: begin
                w_commit     = 1'b1;
                w_next_state = S_HUNT;
                w_next_idx   = '0;
            end
            default: begin
                w_next_state = S_HUNT;
                w_next_idx   = '0;
            end
        endcase
    end

    assign w_sh_we = (r_state == S_RECV) && rx_rd && w_byte_ok;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_sh_x     <= '0;
            r_sh_y     <= '0;
            r_sh_hp    <= '0;
            r_sh_aggro <= '0;
            r_sh_flip  <= 1'b0;
            r_sh_class <= '0;
            r_sh_bx    <= '0;
            r_sh_by    <= '0;
            r_sh_bh    <= '0;
        end else if (w_sh_we) begin
            case (r_idx)
                6'd3:    r_sh_x[11:8]  <= w_nib;
                6'd4:    r_sh_x[7:4]   <= w_nib;
                6'd5:    r_sh_x[3:0]   <= w_nib;
                6'd9:    r_sh_y[11:8]  <= w_nib;
                6'd10:   r_sh_y[7:4]   <= w_nib;
                6'd11:   r_sh_y[3:0]   <= w_nib;
                6'd15:   r_sh_hp       <= w_nib;
                6'd19:   r_sh_aggro    <= w_nib;
                6'd23:   r_sh_flip     <= w_nib[0];
                6'd27:   r_sh_class    <= w_nib[1:0];
                6'd32:   r_sh_bx[11:8] <= w_nib;
                6'd33:   r_sh_bx[7:4]  <= w_nib;
                6'd34:   r_sh_bx[3:0]  <= w_nib;
                6'd38:   r_sh_by[11:8] <= w_nib;
                6'd39:   r_sh_by[7:4]  <= w_nib;
                6'd40:   r_sh_by[3:0]  <= w_nib;
                6'd45:   r_sh_bh[6:4]  <= w_nib[2:0];
                6'd46:   r_sh_bh[3:0]  <= w_nib;
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rem_char_x  <= '0;
            rem_char_y  <= '0;
            rem_char_hp <= '0;
            rem_aggro   <= '0;
            rem_flip_h  <= 1'b0;
            rem_class   <= '0;
            rem_boss_x  <= '0;
            rem_boss_y  <= '0;
            rem_boss_hp <= '0;
            frame_ok    <= 1'b0;
            frame_err   <= 1'b0;
            frame_cnt   <= '0;
        end else begin
            frame_ok  <= w_commit;
            frame_err <= w_err;
            if (w_commit) begin
                rem_char_x  <= r_sh_x;
                rem_char_y  <= r_sh_y;
                rem_char_hp <= r_sh_hp;
                rem_aggro   <= r_sh_aggro;
                rem_flip_h  <= r_sh_flip;
                rem_class   <= r_sh_class;
                rem_boss_x  <= r_sh_bx;
                rem_boss_y  <= r_sh_by;
                rem_boss_hp <= r_sh_bh;
                frame_cnt   <= frame_cnt + 8'd1;
            end
        end
    end

endmodule

// File: tb/tb_uart_game_decoder.sv
// tb_uart_game_decoder
//   Scoreboard bench for uart_game_decoder. Stimulus tasks push expected frames
//   when a good frame is driven; a negedge monitor collects what the DUT reports
//   on frame_ok, and each test task pops and compares.
module tb_uart_game_decoder;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [7:0]  rx_data = 8'h00;
    logic        rx_empty = 1'b1;
    logic        rx_rd;
    logic [11:0] rem_char_x, rem_char_y, rem_boss_x, rem_boss_y;
    logic [3:0]  rem_char_hp, rem_aggro;
    logic        rem_flip_h;
    logic [1:0]  rem_class;
    logic [6:0]  rem_boss_hp;
    logic        frame_ok, frame_err;
    logic [7:0]  frame_cnt;

    always #5 clk = ~clk;

    uart_game_decoder #(
        .DATA_WIDTH     (8),
        .TIMEOUT_CYCLES (100)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .rx_data     (rx_data),
        .rx_empty    (rx_empty),
        .rx_rd       (rx_rd),
        .rem_char_x  (rem_char_x),
        .rem_char_y  (rem_char_y),
        .rem_char_hp (rem_char_hp),
        .rem_aggro   (rem_aggro),
        .rem_flip_h  (rem_flip_h),
        .rem_class   (rem_class),
        .rem_boss_x  (rem_boss_x),
        .rem_boss_y  (rem_boss_y),
        .rem_boss_hp (rem_boss_hp),
        .frame_ok    (frame_ok),
        .frame_err   (frame_err),
        .frame_cnt   (frame_cnt)
    );

    typedef struct packed {
        logic [11:0] x;
        logic [11:0] y;
        logic [3:0]  h;
        logic [3:0]  a;
        logic        f;
        logic [1:0]  t;
        logic [11:0] bx;
        logic [11:0] by;
        logic [6:0]  bh;
    } fld_t;

    typedef struct {
        fld_t       f;
        logic [7:0] cnt;
        int         cyc;
    } ent_t;

    ent_t       exp_q[$];
    ent_t       obs_q[$];
    int         vec_cnt = 0;
    int         err_cnt = 0;
    int         cyc = 0;
    int         stall_cnt = 0;
    int         last_pop_cyc = 0;
    int         err_seen = 0;
    int         chg_bad = 0;
    int         both_hi = 0;
    fld_t       last_good = '0;
    logic [7:0] exp_cnt = 8'd0;
    fld_t       obs_f;
    fld_t       prev_f = '0;

    assign obs_f = {rem_char_x, rem_char_y, rem_char_hp, rem_aggro, rem_flip_h,
                    rem_class, rem_boss_x, rem_boss_y, rem_boss_hp};

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        ent_t o;
        if (rst) begin
            prev_f = '0;
        end else begin
            if (frame_ok) begin
                o.f   = obs_f;
                o.cnt = frame_cnt;
                o.cyc = cyc;
                obs_q.push_back(o);
            end
            if (frame_err) err_seen++;
            if (frame_ok && frame_err) both_hi++;
            if (obs_f !== prev_f && !frame_ok) chg_bad++;
            prev_f = obs_f;
        end
    end

    function automatic logic [7:0] dig(input logic [3:0] n);
        return 8'h30 + {4'h0, n};
    endfunction

    function automatic logic [7:0] byte_at(input fld_t s, input int p);
        string tmpl;
        tmpl = "CX:000,Y:000|H:0|A:0|F:0|T:0|BX:000,Y:000|BH:00";
        case (p)
            3:  return dig(s.x[11:8]);
            4:  return dig(s.x[7:4]);
            5:  return dig(s.x[3:0]);
            9:  return dig(s.y[11:8]);
            10: return dig(s.y[7:4]);
            11: return dig(s.y[3:0]);
            15: return dig(s.h);
            19: return dig(s.a);
            23: return {7'b0011000, s.f};
            27: return {6'b001100, s.t};
            32: return dig(s.bx[11:8]);
            33: return dig(s.bx[7:4]);
            34: return dig(s.bx[3:0]);
            38: return dig(s.by[11:8]);
            39: return dig(s.by[7:4]);
            40: return dig(s.by[3:0]);
            45: return {5'b00110, s.bh[6:4]};
            46: return dig(s.bh[3:0]);
            47: return 8'h0D;
            48: return 8'h0A;
            default: return tmpl[p];
        endcase
    endfunction

    function automatic fld_t rand_fld();
        fld_t s;
        s.x  = 12'($urandom());
        s.y  = 12'($urandom());
        s.h  = 4'($urandom());
        s.a  = 4'($urandom());
        s.f  = 1'($urandom());
        s.t  = 2'($urandom());
        s.bx = 12'($urandom());
        s.by = 12'($urandom());
        s.bh = 7'($urandom());
        return s;
    endfunction

    // Offer one byte at a negedge and wait until the DUT pops it.
    task automatic push_byte(input logic [7:0] b);
        int t = 0;
        rx_data  = b;
        rx_empty = 1'b0;
        #1;
        while (!rx_rd && t < 4) begin
            stall_cnt++;
            t++;
            @(negedge clk);
            #1;
        end
        if (!rx_rd) begin
            vec_cnt++;
            err_cnt++;
            $display("FAIL pop_timeout: rx_rd=%b after %0d cycles, want 1", rx_rd, t);
        end
        @(posedge clk);
        @(negedge clk);
        last_pop_cyc = cyc;
    endtask

    task automatic send_frame(input fld_t s, input int nbytes, input int bad_pos,
                              input logic [7:0] bad_val);
        for (int p = 0; p < nbytes; p++)
            push_byte((p == bad_pos) ? bad_val : byte_at(s, p));
    endtask

    task automatic expect_good(input fld_t s);
        ent_t e;
        exp_cnt   = exp_cnt + 8'd1;
        e.f       = s;
        e.cnt     = exp_cnt;
        e.cyc     = last_pop_cyc + 1;
        last_good = s;
        exp_q.push_back(e);
    endtask

    task automatic idle(input int n);
        rx_empty = 1'b1;
        repeat (n) @(negedge clk);
    endtask

    task automatic reset_dut();
        rx_empty = 1'b1;
        rst = 1'b1;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        exp_cnt   = 8'd0;
        last_good = '0;
        exp_q.delete();
        obs_q.delete();
        @(negedge clk);
    endtask

    task automatic test_reset();
        rx_empty = 1'b1;
        rst = 1'b1;
        repeat (2) @(negedge clk);
        vec_cnt++;
        if (obs_f !== '0) begin
            err_cnt++;
            $display("FAIL reset_rem: got %h want 0", obs_f);
        end
        vec_cnt++;
        if ({frame_cnt, frame_ok, frame_err, rx_rd} !== 11'd0) begin
            err_cnt++;
            $display("FAIL reset_flags: got cnt=%0d ok=%b err=%b rd=%b want all 0",
                     frame_cnt, frame_ok, frame_err, rx_rd);
        end
        rst = 1'b0;
        idle(2);
    endtask

    task automatic test_good_frame();
        int   e0 = err_seen;
        ent_t e, o;
        fld_t s;
        s = '{x: 12'h123, y: 12'h0A5, h: 4'd7, a: 4'd2, f: 1'b1, t: 2'd3,
              bx: 12'h200, by: 12'h150, bh: 7'h64};
        send_frame(s, 49, -1, 8'h00);
        expect_good(s);
        idle(4);
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            vec_cnt++;
            if (obs_q.size() == 0) begin
                err_cnt++; $display("FAIL good_missing: got no frame_ok, want cnt=%0d", e.cnt);
            end else begin
                o = obs_q.pop_front();
                if (o.f !== e.f || o.cnt !== e.cnt || o.cyc != e.cyc) begin
                    err_cnt++;
                    $display("FAIL good_frame: got %h cnt=%0d @%0d want %h cnt=%0d @%0d",
                             o.f, o.cnt, o.cyc, e.f, e.cnt, e.cyc);
                end
            end
        end
        vec_cnt++;
        if (obs_q.size() != 0 || err_seen != e0) begin
            err_cnt++;
            $display("FAIL good_extra: got %0d extra ok, %0d err want 0/0", obs_q.size(), err_seen - e0);
        end
        obs_q.delete();
        vec_cnt++;
        if (frame_cnt !== 8'd1 || rem_boss_hp !== 7'h64) begin
            err_cnt++;
            $display("FAIL good_hold: got cnt=%0d bh=%h want 1/64", frame_cnt, rem_boss_hp);
        end
    endtask

    task automatic test_bad_template();
        int   e0 = err_seen;
        ent_t e, o;
        fld_t s;
        s = rand_fld();
        send_frame(s, 49, -1, 8'h00);
        expect_good(s);
        send_frame(rand_fld(), 49, 12, 8'h23);
        idle(4);
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            vec_cnt++;
            if (obs_q.size() == 0) begin
                err_cnt++; $display("FAIL tmpl_missing: got no frame_ok, want cnt=%0d", e.cnt);
            end else begin
                o = obs_q.pop_front();
                if (o.f !== e.f || o.cnt !== e.cnt || o.cyc != e.cyc) begin
                    err_cnt++;
                    $display("FAIL tmpl_frame: got %h cnt=%0d @%0d want %h cnt=%0d @%0d",
                             o.f, o.cnt, o.cyc, e.f, e.cnt, e.cyc);
                end
            end
        end
        vec_cnt++;
        if (obs_q.size() != 0 || err_seen - e0 != 1) begin
            err_cnt++;
            $display("FAIL tmpl_err: got %0d extra ok, %0d err want 0/1", obs_q.size(), err_seen - e0);
        end
        obs_q.delete();
        vec_cnt++;
        if (obs_f !== last_good || frame_cnt !== exp_cnt) begin
            err_cnt++;
            $display("FAIL tmpl_hold: got %h cnt=%0d want %h cnt=%0d", obs_f, frame_cnt, last_good, exp_cnt);
        end
    endtask

    task automatic test_resync();
        int   e0 = err_seen;
        ent_t e, o;
        fld_t s;
        push_byte(8'h78);
        push_byte(8'h79);
        push_byte(8'h7A);
        send_frame(rand_fld(), 20, -1, 8'h00);
        s = rand_fld();
        send_frame(s, 49, -1, 8'h00);
        expect_good(s);
        idle(4);
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            vec_cnt++;
            if (obs_q.size() == 0) begin
                err_cnt++; $display("FAIL resync_missing: got no frame_ok, want cnt=%0d", e.cnt);
            end else begin
                o = obs_q.pop_front();
                if (o.f !== e.f || o.cnt !== e.cnt || o.cyc != e.cyc) begin
                    err_cnt++;
                    $display("FAIL resync_frame: got %h cnt=%0d @%0d want %h cnt=%0d @%0d",
                             o.f, o.cnt, o.cyc, e.f, e.cnt, e.cyc);
                end
            end
        end
        vec_cnt++;
        if (obs_q.size() != 0 || err_seen - e0 != 1) begin
            err_cnt++;
            $display("FAIL resync_err: got %0d extra ok, %0d err want 0/1", obs_q.size(), err_seen - e0);
        end
        obs_q.delete();
    endtask

    task automatic test_range();
        int e0 = err_seen;
        send_frame(rand_fld(), 49, 45, 8'h39);
        send_frame(rand_fld(), 49, 23, 8'h32);
        idle(4);
        vec_cnt++;
        if (obs_q.size() != 0 || err_seen - e0 != 2) begin
            err_cnt++;
            $display("FAIL range_err: got %0d ok, %0d err want 0/2", obs_q.size(), err_seen - e0);
        end
        obs_q.delete();
        vec_cnt++;
        if (obs_f !== last_good || frame_cnt !== exp_cnt) begin
            err_cnt++;
            $display("FAIL range_hold: got %h cnt=%0d want %h cnt=%0d", obs_f, frame_cnt, last_good, exp_cnt);
        end
        vec_cnt++;
        if (chg_bad != 0 || both_hi != 0) begin
            err_cnt++;
            $display("FAIL stray_change: got %0d silent changes, %0d ok+err want 0/0", chg_bad, both_hi);
        end
    endtask

    task automatic test_back_to_back();
        int   s0 = stall_cnt;
        ent_t e, o;
        fld_t s;
        for (int i = 0; i < 2; i++) begin
            s = rand_fld();
            send_frame(s, 49, -1, 8'h00);
            expect_good(s);
        end
        idle(4);
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            vec_cnt++;
            if (obs_q.size() == 0) begin
                err_cnt++; $display("FAIL b2b_missing: got no frame_ok, want cnt=%0d", e.cnt);
            end else begin
                o = obs_q.pop_front();
                if (o.f !== e.f || o.cnt !== e.cnt || o.cyc != e.cyc) begin
                    err_cnt++;
                    $display("FAIL b2b_frame: got %h cnt=%0d @%0d want %h cnt=%0d @%0d",
                             o.f, o.cnt, o.cyc, e.f, e.cnt, e.cyc);
                end
            end
        end
        vec_cnt++;
        if (stall_cnt - s0 != 1 || obs_q.size() != 0) begin
            err_cnt++;
            $display("FAIL b2b_stall: got %0d stalls, %0d extra ok want 1/0", stall_cnt - s0, obs_q.size());
        end
        obs_q.delete();
    endtask

    task automatic test_wrap();
        int   s0;
        ent_t e, o;
        fld_t s;
        reset_dut();
        s0 = stall_cnt;
        for (int i = 0; i < 256; i++) begin
            s = rand_fld();
            send_frame(s, 49, -1, 8'h00);
            expect_good(s);
        end
        idle(4);
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            vec_cnt++;
            if (obs_q.size() == 0) begin
                err_cnt++; $display("FAIL wrap_missing: got no frame_ok, want cnt=%0d", e.cnt);
            end else begin
                o = obs_q.pop_front();
                if (o.f !== e.f || o.cnt !== e.cnt || o.cyc != e.cyc) begin
                    err_cnt++;
                    $display("FAIL wrap_frame: got %h cnt=%0d @%0d want %h cnt=%0d @%0d",
                             o.f, o.cnt, o.cyc, e.f, e.cnt, e.cyc);
                end
            end
        end
        vec_cnt++;
        if (stall_cnt - s0 != 255 || frame_cnt !== 8'd0) begin
            err_cnt++;
            $display("FAIL wrap_cnt: got %0d stalls cnt=%0d want 255/0", stall_cnt - s0, frame_cnt);
        end
        obs_q.delete();
    endtask

    task automatic test_reset_midframe();
        int   e0 = err_seen;
        ent_t e, o;
        fld_t s;
        send_frame(rand_fld(), 30, -1, 8'h00);
        rx_empty = 1'b1;
        #2 rst = 1'b1;
        #1;
        vec_cnt++;
        if (obs_f !== '0 || frame_cnt !== 8'd0) begin
            err_cnt++;
            $display("FAIL async_rst: got %h cnt=%0d want 0/0", obs_f, frame_cnt);
        end
        @(negedge clk);
        rst = 1'b0;
        exp_cnt   = 8'd0;
        last_good = '0;
        obs_q.delete();
        idle(2);
        s = rand_fld();
        send_frame(s, 49, -1, 8'h00);
        expect_good(s);
        idle(4);
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            vec_cnt++;
            if (obs_q.size() == 0) begin
                err_cnt++; $display("FAIL rst_missing: got no frame_ok, want cnt=%0d", e.cnt);
            end else begin
                o = obs_q.pop_front();
                if (o.f !== e.f || o.cnt !== e.cnt || o.cyc != e.cyc) begin
                    err_cnt++;
                    $display("FAIL rst_frame: got %h cnt=%0d @%0d want %h cnt=%0d @%0d",
                             o.f, o.cnt, o.cyc, e.f, e.cnt, e.cyc);
                end
            end
        end
        vec_cnt++;
        if (err_seen != e0 || obs_q.size() != 0) begin
            err_cnt++;
            $display("FAIL rst_err: got %0d err, %0d extra ok want 0/0", err_seen - e0, obs_q.size());
        end
        obs_q.delete();
    endtask

`ifdef UART_DEC_TIMEOUT_EN
    task automatic test_timeout();
        int   e0 = err_seen;
        ent_t e, o;
        fld_t s;
        send_frame(rand_fld(), 10, -1, 8'h00);
        idle(150);
        vec_cnt++;
        if (err_seen - e0 != 1) begin
            err_cnt++;
            $display("FAIL timeout_err: got %0d err want 1", err_seen - e0);
        end
        s = rand_fld();
        send_frame(s, 49, -1, 8'h00);
        expect_good(s);
        idle(4);
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            vec_cnt++;
            if (obs_q.size() == 0) begin
                err_cnt++; $display("FAIL to_missing: got no frame_ok, want cnt=%0d", e.cnt);
            end else begin
                o = obs_q.pop_front();
                if (o.f !== e.f || o.cnt !== e.cnt || o.cyc != e.cyc) begin
                    err_cnt++;
                    $display("FAIL to_frame: got %h cnt=%0d @%0d want %h cnt=%0d @%0d",
                             o.f, o.cnt, o.cyc, e.f, e.cnt, e.cyc);
                end
            end
        end
        obs_q.delete();
    endtask
`endif

    initial begin
        test_reset();
        test_good_frame();
        test_bad_template();
        test_resync();
        test_range();
        test_back_to_back();
        test_wrap();
        test_reset_midframe();
`ifdef UART_DEC_TIMEOUT_EN
        test_timeout();
`endif
        $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
        $finish;
    end

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation still running at %0t, want finished", $time);
        $fatal(1, "watchdog expired");
    end

endmodule
